// File: rtl/local_port_input_buffer.sv
// Router-side inject buffer: credit-sized FIFO that holds PE flits for the switch
// and returns one credit per flit drained.
module local_port_input_buffer #(
  parameter int FLIT_W = 20,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] in,
  input  logic              vi,
  output logic              co,
  output logic [FLIT_W-1:0] o,
  output logic              vo,
  input  logic              pop,
  output logic [CNT_W-1:0]  count,
  output logic              ovf
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              co_reg;
  logic              ovf_reg, ovf_next;
  logic              pop_eff;
  logic              wr_eff;

  assign vo    = (count_reg != '0);
  assign o     = vo ? mem[rd_ptr_reg] : '0;
  assign count = count_reg;
  assign co    = co_reg;
  assign ovf   = ovf_reg;

  // A pop at full frees the slot the incoming flit needs in the same cycle.
  assign pop_eff = pop & vo;
  assign wr_eff  = vi & ((count_reg != FULL) | pop_eff);

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    ovf_next    = ovf_reg;
    if (pop_eff) rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    if (wr_eff)  wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    if (wr_eff && !pop_eff)      count_next = count_reg + CNT_W'(1);
    else if (pop_eff && !wr_eff) count_next = count_reg - CNT_W'(1);
    if (vi && !wr_eff) ovf_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      co_reg     <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      co_reg     <= pop_eff;
      ovf_reg    <= ovf_next;
    end
  end

  // Storage is deliberately left out of reset; only the pointers define contents.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (!rst && wr_eff && (wr_ptr_reg == PTR_W'(gi)))
        mem[gi] <= in;
    end
  end

endmodule

// File: tb/tb_local_port_input_buffer.sv
// Self-checking bench for local_port_input_buffer: directed vector table followed
// by randomized traffic against a queue-based model of the buffer.
module tb_local_port_input_buffer;

  localparam int FLIT_W = 20;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  logic              clk;
  logic              rst;
  logic [FLIT_W-1:0] in;
  logic              vi;
  logic              co;
  logic [FLIT_W-1:0] o;
  logic              vo;
  logic              pop;
  logic [CNT_W-1:0]  count;
  logic              ovf;

  int checks;
  int failures;

  local_port_input_buffer #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in(in), .vi(vi), .co(co),
    .o(o), .vo(vo), .pop(pop), .count(count), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              rst;
    logic              vi;
    logic [FLIT_W-1:0] din;
    logic              pop;
    logic [CNT_W-1:0]  cnt;
    logic              vo;
    logic [FLIT_W-1:0] dout;
    logic              co;
    logic              ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic v, input logic [FLIT_W-1:0] d,
                              input logic p, input int c, input logic evo,
                              input logic [FLIT_W-1:0] eo, input logic eco, input logic eovf);
    vec_t t;
    t.rst = r; t.vi = v; t.din = d; t.pop = p;
    t.cnt = CNT_W'(c); t.vo = evo; t.dout = eo; t.co = eco; t.ovf = eovf;
    return t;
  endfunction

  task automatic check(input string name, input logic [FLIT_W-1:0] act, input logic [FLIT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs just after an edge, then sample 1 ns after the following edge.
  task automatic step(input logic r, input logic v, input logic [FLIT_W-1:0] d, input logic p);
    rst = r; vi = v; in = d; pop = p;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int c, input logic evo,
                           input logic [FLIT_W-1:0] eo, input logic eco, input logic eovf);
    check({tag, ".count"}, FLIT_W'(count), FLIT_W'(c));
    check({tag, ".vo"},    FLIT_W'(vo),    FLIT_W'(evo));
    check({tag, ".o"},     o,              eo);
    check({tag, ".co"},    FLIT_W'(co),    FLIT_W'(eco));
    check({tag, ".ovf"},   FLIT_W'(ovf),   FLIT_W'(eovf));
  endtask

  // Behavioural reference: the buffer is just a bounded queue of flits.
  logic [FLIT_W-1:0] model_q[$];
  logic              model_co;
  logic              model_ovf;

  task automatic model_step(input logic r, input logic v, input logic [FLIT_W-1:0] d, input logic p);
    bit can_pop;
    bit can_write;
    if (r) begin
      model_q.delete();
      model_co  = 1'b0;
      model_ovf = 1'b0;
    end else begin
      can_pop   = p && (model_q.size() > 0);
      can_write = v && ((model_q.size() < DEPTH) || can_pop);
      if (v && !can_write) model_ovf = 1'b1;
      if (can_pop) void'(model_q.pop_front());
      if (can_write) model_q.push_back(d);
      model_co = can_pop;
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; vi = 1'b0; in = '0; pop = 1'b0;
    model_co = 1'b0; model_ovf = 1'b0;

    //                  rst vi  din       pop cnt vo  o         co  ovf
    // reset held two cycles
    vecs.push_back(mk(1, 0, 20'h00000, 0, 0, 0, 20'h00000, 0, 0));
    vecs.push_back(mk(1, 0, 20'h00000, 0, 0, 0, 20'h00000, 0, 0));
    // single flit, then pop with credit next cycle
    vecs.push_back(mk(0, 1, 20'hA5A5A, 0, 1, 1, 20'hA5A5A, 0, 0));
    vecs.push_back(mk(0, 0, 20'h00000, 1, 0, 0, 20'h00000, 1, 0));
    vecs.push_back(mk(0, 0, 20'h00000, 0, 0, 0, 20'h00000, 0, 0));
    // pop while empty is ignored
    vecs.push_back(mk(0, 0, 20'h00000, 1, 0, 0, 20'h00000, 0, 0));
    vecs.push_back(mk(0, 0, 20'h00000, 0, 0, 0, 20'h00000, 0, 0));
    // fill and wrap
    vecs.push_back(mk(0, 1, 20'h00001, 0, 1, 1, 20'h00001, 0, 0));
    vecs.push_back(mk(0, 1, 20'h00002, 0, 2, 1, 20'h00001, 0, 0));
    vecs.push_back(mk(0, 1, 20'h00003, 0, 3, 1, 20'h00001, 0, 0));
    vecs.push_back(mk(0, 1, 20'h00004, 0, 4, 1, 20'h00001, 0, 0));
    vecs.push_back(mk(0, 0, 20'h00000, 1, 3, 1, 20'h00002, 1, 0));
    vecs.push_back(mk(0, 0, 20'h00000, 1, 2, 1, 20'h00003, 1, 0));
    vecs.push_back(mk(0, 1, 20'h00005, 0, 3, 1, 20'h00003, 0, 0));
    vecs.push_back(mk(0, 1, 20'h00006, 0, 4, 1, 20'h00003, 0, 0));
    vecs.push_back(mk(0, 0, 20'h00000, 1, 3, 1, 20'h00004, 1, 0));
    vecs.push_back(mk(0, 0, 20'h00000, 1, 2, 1, 20'h00005, 1, 0));
    vecs.push_back(mk(0, 0, 20'h00000, 1, 1, 1, 20'h00006, 1, 0));
    vecs.push_back(mk(0, 0, 20'h00000, 1, 0, 0, 20'h00000, 1, 0));
    vecs.push_back(mk(0, 0, 20'h00000, 0, 0, 0, 20'h00000, 0, 0));
    // full with simultaneous pop accepts the new flit
    vecs.push_back(mk(0, 1, 20'h00007, 0, 1, 1, 20'h00007, 0, 0));
    vecs.push_back(mk(0, 1, 20'h00008, 0, 2, 1, 20'h00007, 0, 0));
    vecs.push_back(mk(0, 1, 20'h00009, 0, 3, 1, 20'h00007, 0, 0));
    vecs.push_back(mk(0, 1, 20'h0000A, 0, 4, 1, 20'h00007, 0, 0));
    vecs.push_back(mk(0, 1, 20'h0BEEF, 1, 4, 1, 20'h00008, 1, 0));
    vecs.push_back(mk(0, 0, 20'h00000, 1, 3, 1, 20'h00009, 1, 0));
    vecs.push_back(mk(0, 0, 20'h00000, 1, 2, 1, 20'h0000A, 1, 0));
    vecs.push_back(mk(0, 0, 20'h00000, 1, 1, 1, 20'h0BEEF, 1, 0));
    vecs.push_back(mk(0, 0, 20'h00000, 1, 0, 0, 20'h00000, 1, 0));
    // overflow drops the flit and sets sticky ovf
    vecs.push_back(mk(0, 1, 20'h00011, 0, 1, 1, 20'h00011, 0, 0));
    vecs.push_back(mk(0, 1, 20'h00012, 0, 2, 1, 20'h00011, 0, 0));
    vecs.push_back(mk(0, 1, 20'h00013, 0, 3, 1, 20'h00011, 0, 0));
    vecs.push_back(mk(0, 1, 20'h00014, 0, 4, 1, 20'h00011, 0, 0));
    vecs.push_back(mk(0, 1, 20'hFFFFF, 0, 4, 1, 20'h00011, 0, 1));
    vecs.push_back(mk(0, 0, 20'h00000, 0, 4, 1, 20'h00011, 0, 1));
    vecs.push_back(mk(0, 0, 20'h00000, 1, 3, 1, 20'h00012, 1, 1));
    vecs.push_back(mk(0, 0, 20'h00000, 1, 2, 1, 20'h00013, 1, 1));
    vecs.push_back(mk(0, 0, 20'h00000, 1, 1, 1, 20'h00014, 1, 1));
    vecs.push_back(mk(0, 0, 20'h00000, 1, 0, 0, 20'h00000, 1, 1));
    vecs.push_back(mk(0, 0, 20'h00000, 0, 0, 0, 20'h00000, 0, 1));
    // reset coincident with a pop at count 2
    vecs.push_back(mk(0, 1, 20'h00021, 0, 1, 1, 20'h00021, 0, 1));
    vecs.push_back(mk(0, 1, 20'h00022, 0, 2, 1, 20'h00021, 0, 1));
    vecs.push_back(mk(1, 0, 20'h00000, 1, 0, 0, 20'h00000, 0, 0));
    vecs.push_back(mk(0, 0, 20'h00000, 0, 0, 0, 20'h00000, 0, 0));
    // no bypass: same-cycle pop into an empty buffer is ignored
    vecs.push_back(mk(0, 1, 20'h00033, 1, 1, 1, 20'h00033, 0, 0));
    vecs.push_back(mk(0, 0, 20'h00000, 1, 0, 0, 20'h00000, 1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].vi, vecs[i].din, vecs[i].pop);
      $display("vec %0d rst=%0b vi=%0b in=%h pop=%0b -> count=%0d vo=%0b o=%h co=%0b ovf=%0b",
               i, vecs[i].rst, vecs[i].vi, vecs[i].din, vecs[i].pop, count, vo, o, co, ovf);
      check_all($sformatf("vec%0d", i), int'(vecs[i].cnt), vecs[i].vo, vecs[i].dout,
                vecs[i].co, vecs[i].ovf);
    end

    // Randomized traffic against the queue model, starting from a clean reset.
    step(1'b1, 1'b0, '0, 1'b0);
    model_step(1'b1, 1'b0, '0, 1'b0);
    for (int n = 0; n < 2000; n++) begin
      logic              r_r, r_v, r_p;
      logic [FLIT_W-1:0] r_d;
      logic [FLIT_W-1:0] exp_o;
      r_r = ($urandom_range(0, 99) == 0);
      r_v = ($urandom_range(0, 99) < 60);
      r_p = ($urandom_range(0, 99) < 45);
      r_d = FLIT_W'($urandom);
      step(r_r, r_v, r_d, r_p);
      model_step(r_r, r_v, r_d, r_p);
      exp_o = (model_q.size() > 0) ? model_q[0] : '0;
      $display("rnd %0d rst=%0b vi=%0b in=%h pop=%0b -> count=%0d o=%h co=%0b ovf=%0b",
               n, r_r, r_v, r_d, r_p, count, o, co, ovf);
      check_all($sformatf("rnd%0d", n), model_q.size(), (model_q.size() > 0), exp_o,
                model_co, model_ovf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
